// File: rtl/core_pkg.sv
// Shared loader/decoder definitions: opcode constants, loader FSM states and status bytes.
package core_pkg;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpCalci  = 7'b0010011;
  localparam logic [6:0] OpCalc   = 7'b0110011;
  localparam logic [6:0] OpFload  = 7'b0000111;
  localparam logic [6:0] OpFstore = 7'b0100111;
  localparam logic [6:0] OpF      = 7'b1010011;

  localparam logic [7:0] StatusOk  = 8'hAA;
  localparam logic [7:0] StatusBad = 8'hEE;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StAck,
    StDone
  } loader_state_t;

  function automatic logic is_supported_op(logic [6:0] op);
    return op inside {OpLui, OpAuipc, OpJal, OpJalr, OpBranch, OpLoad,
                      OpStore, OpCalci, OpCalc, OpFload, OpFstore, OpF};
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte stream in, status byte out and instruction-memory write port of the loader.
interface program_loader_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;

  modport master (
    input  rx_valid, rx_data, tx_ready,
    output imem_we, imem_addr, imem_wdata, tx_valid, tx_data
  );

  modport slave (
    output rx_valid, rx_data, tx_ready,
    input  imem_we, imem_addr, imem_wdata, tx_valid, tx_data
  );
endinterface

// File: rtl/word_assembler.sv
// Collects four bytes (LSB first) into a 32-bit word; word_o/done_o are valid in the
// cycle the fourth byte is presented.
module word_assembler (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr_i,
  input  logic        valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        done_o
);

  // Only the three earlier bytes need storage; the fourth comes straight from byte_i.
  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (valid_i) begin
      shift_d = {byte_i, shift_q[23:8]};
      cnt_d   = cnt_q + 2'd1;
    end
  end

  assign word_o = {byte_i, shift_q};
  assign done_o = valid_i && !clr_i && (cnt_q == 2'd3);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed byte stream into instruction memory, checks opcodes and
// reports a one-byte status over the transmit handshake.
module program_loader
  import core_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             bad_op,
  program_loader_if.master bus
);

  localparam logic [32:0] Depth = 33'(1) << ADDR_W;

  loader_state_t     state_q, state_d;
  logic [31:0]       idx_q, idx_d;
  logic [31:0]       len_q, len_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bad_op_q, bad_op_d;

  logic        asm_clr;
  logic        asm_valid;
  logic [31:0] asm_word;
  logic        asm_done;
  logic        in_range;
  logic        word_bad;

  // Bytes outside LEN/DATA never reach the assembler, so they are simply dropped.
  assign asm_valid = bus.rx_valid && ((state_q == StLen) || (state_q == StData));
  assign in_range  = {1'b0, idx_q} < Depth;

  word_assembler u_word_assembler (
    .clk     (clk),
    .rstn    (rstn),
    .clr_i   (asm_clr),
    .valid_i (asm_valid),
    .byte_i  (bus.rx_data),
    .word_o  (asm_word),
    .done_o  (asm_done)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    len_d        = len_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    busy_d       = busy_q;
    done_d       = done_q;
    bad_op_d     = bad_op_q;
    asm_clr      = 1'b0;
    word_bad     = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StLen;
          idx_d    = '0;
          len_d    = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          bad_op_d = 1'b0;
          asm_clr  = 1'b1;
        end
      end
      StLen: begin
        if (asm_done) begin
          len_d = asm_word;
          if (asm_word == '0) begin
            state_d    = StAck;
            tx_valid_d = 1'b1;
            tx_data_d  = bad_op_q ? StatusBad : StatusOk;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (asm_done) begin
          // Words past the memory depth are consumed but flagged instead of written.
          word_bad = !is_supported_op(asm_word[6:0]) || !in_range;
          if (in_range) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = idx_q[ADDR_W-1:0];
            imem_wdata_d = asm_word;
          end
          bad_op_d = bad_op_q | word_bad;
          idx_d    = idx_q + 32'd1;
          if (idx_d == len_q) begin
            state_d    = StAck;
            tx_valid_d = 1'b1;
            tx_data_d  = (bad_op_q | word_bad) ? StatusBad : StatusOk;
          end
        end
      end
      StAck: begin
        if (bus.tx_ready) begin
          state_d    = StDone;
          tx_valid_d = 1'b0;
          tx_data_d  = '0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      len_q        <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      bad_op_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      bad_op_q     <= bad_op_d;
    end
  end

  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.tx_data    = tx_data_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign bad_op         = bad_op_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench: two loaders (depth 4096 and depth 4) share one stimulus stream;
// expected writes/status bytes are queued per instance and popped by negedge monitors.
module tb_program_loader;

  logic       clk;
  logic       rstn;
  logic       start;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_ready;
  logic       busy12, done12, bad12;
  logic       busy2, done2, bad2;

  program_loader_if #(.ADDR_W(12)) bus12 ();
  program_loader_if #(.ADDR_W(2))  bus2 ();

  assign bus12.rx_valid = rx_valid;
  assign bus12.rx_data  = rx_data;
  assign bus12.tx_ready = tx_ready;
  assign bus2.rx_valid  = rx_valid;
  assign bus2.rx_data   = rx_data;
  assign bus2.tx_ready  = tx_ready;

  program_loader #(.ADDR_W(12)) u_dut12 (
    .clk    (clk),
    .rstn   (rstn),
    .start  (start),
    .busy   (busy12),
    .done   (done12),
    .bad_op (bad12),
    .bus    (bus12)
  );

  program_loader #(.ADDR_W(2)) u_dut2 (
    .clk    (clk),
    .rstn   (rstn),
    .start  (start),
    .busy   (busy2),
    .done   (done2),
    .bad_op (bad2),
    .bus    (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_wr12 [$];
  logic [63:0] exp_wr2  [$];
  logic [7:0]  exp_tx12 [$];
  logic [7:0]  exp_tx2  [$];
  logic [31:0] prog     [$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitors: every write and every offered status byte must match the queue head.
  logic [63:0] e12, e2;
  logic [8:0]  t12, t2;

  always @(negedge clk) begin
    if (rstn) begin
      if (bus12.imem_we) begin
        e12 = '1;
        if (exp_wr12.size() > 0) e12 = exp_wr12.pop_front();
        check("wr12", {32'(bus12.imem_addr), bus12.imem_wdata}, e12);
      end
      if (bus12.tx_valid) begin
        t12 = 9'h1FF;
        if (exp_tx12.size() > 0) t12 = {1'b0, exp_tx12[0]};
        check("tx12", 64'(bus12.tx_data), 64'(t12));
        if (tx_ready && exp_tx12.size() > 0) exp_tx12.delete(0);
      end
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (bus2.imem_we) begin
        e2 = '1;
        if (exp_wr2.size() > 0) e2 = exp_wr2.pop_front();
        check("wr2", {32'(bus2.imem_addr), bus2.imem_wdata}, e2);
      end
      if (bus2.tx_valid) begin
        t2 = 9'h1FF;
        if (exp_tx2.size() > 0) t2 = {1'b0, exp_tx2[0]};
        check("tx2", 64'(bus2.tx_data), 64'(t2));
        if (tx_ready && exp_tx2.size() > 0) exp_tx2.delete(0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_expect(input bit b12, input bit b2);
    for (int i = 0; i < prog.size(); i++) begin
      if (i < 4096) exp_wr12.push_back({32'(i), prog[i]});
      if (i < 4)    exp_wr2.push_back({32'(i), prog[i]});
    end
    exp_tx12.push_back(b12 ? 8'hEE : 8'hAA);
    exp_tx2.push_back(b2 ? 8'hEE : 8'hAA);
  endtask

  task automatic zero_checks(input string name);
    check({name, "_zero12"}, 64'({bus12.imem_we, bus12.imem_addr, bus12.imem_wdata,
          bus12.tx_valid, bus12.tx_data, busy12, done12, bad12}), 64'd0);
    check({name, "_zero2"}, 64'({bus2.imem_we, bus2.imem_addr, bus2.imem_wdata,
          bus2.tx_valid, bus2.tx_data, busy2, done2, bad2}), 64'd0);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!(done12 && done2) && n < 200) begin
      tick();
      n++;
    end
    check({name, "_done_in_time"}, 64'(done12 && done2), 64'd1);
  endtask

  task automatic end_checks(input string name, input bit b12, input bit b2);
    check({name, "_status12"}, 64'({done12, busy12, bad12}), 64'({1'b1, 1'b0, b12}));
    check({name, "_status2"}, 64'({done2, busy2, bad2}), 64'({1'b1, 1'b0, b2}));
    check({name, "_queues_empty"},
          64'(exp_wr12.size() + exp_wr2.size() + exp_tx12.size() + exp_tx2.size()), 64'd0);
  endtask

  task automatic run(input string name, input bit b12, input bit b2);
    pulse_start();
    check({name, "_start12"}, 64'({busy12, done12, bad12}), 64'(3'b100));
    check({name, "_start2"}, 64'({busy2, done2, bad2}), 64'(3'b100));
    push_expect(b12, b2);
    send_word(32'(prog.size()));
    foreach (prog[i]) send_word(prog[i]);
    wait_done(name);
    end_checks(name, b12, b2);
  endtask

  logic [31:0] mix_ops [9] = '{32'h000000B7, 32'h00000063, 32'h00002023, 32'h00002027,
                               32'h00000067, 32'h00000033, 32'h00002083, 32'h00002007,
                               32'h00000053};

  initial begin
    rstn     = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    tx_ready = 1'b1;
    tick();
    tick();
    zero_checks("reset");
    rstn = 1'b1;
    tick();

    // One-word program; ACK lasts exactly one cycle with tx_ready already high.
    prog.delete();
    prog.push_back(32'h00A00513);
    pulse_start();
    push_expect(1'b0, 1'b0);
    send_word(32'd1);
    send_word(prog[0]);
    check("s1_ack12", 64'({bus12.tx_valid, busy12, done12}), 64'(3'b110));
    check("s1_ack2", 64'({bus2.tx_valid, busy2, done2}), 64'(3'b110));
    tick();
    check("s1_done12", 64'({bus12.tx_valid, busy12, done12}), 64'(3'b001));
    end_checks("s1", 1'b0, 1'b0);

    // Zero length; the byte arriving with start is dropped.
    start    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    tick();
    start    = 1'b0;
    rx_valid = 1'b0;
    prog.delete();
    push_expect(1'b0, 1'b0);
    send_word(32'd0);
    check("s2_ack_direct", 64'({bus12.tx_valid, bus2.tx_valid}), 64'(2'b11));
    wait_done("s2");
    end_checks("s2", 1'b0, 1'b0);

    // Five words: fits in depth 4096, overflows depth 4.
    prog.delete();
    repeat (5) prog.push_back(32'h00000013);
    run("s3", 1'b0, 1'b1);

    // Unsupported opcode is still written.
    prog.delete();
    prog.push_back(32'h00000013);
    prog.push_back(32'hFFFFFFFF);
    run("s4", 1'b1, 1'b1);

    // Reset in the middle of word 1; the partial word is never written.
    pulse_start();
    exp_wr12.push_back({32'd0, 32'hFFFFFFFF});
    exp_wr2.push_back({32'd0, 32'hFFFFFFFF});
    send_word(32'd2);
    send_word(32'hFFFFFFFF);
    send_byte(8'h13);
    send_byte(8'h00);
    rstn = 1'b0;
    #1;
    zero_checks("s5_reset");
    check("s5_first_written", 64'(exp_wr12.size() + exp_wr2.size()), 64'd0);
    tick();
    rstn = 1'b1;
    tick();
    prog.delete();
    prog.push_back(32'h00000297);
    run("s5", 1'b0, 1'b0);

    // Start ignored mid-LEN; tx_ready low for 10 ACK cycles with bytes arriving.
    prog.delete();
    prog.push_back(32'h0000006F);
    pulse_start();
    push_expect(1'b0, 1'b0);
    send_byte(8'h01);
    send_byte(8'h00);
    start = 1'b1;
    tick();
    start = 1'b0;
    send_byte(8'h00);
    send_byte(8'h00);
    tx_ready = 1'b0;
    send_word(prog[0]);
    for (int i = 0; i < 10; i++) begin
      check("s6_ack_hold", 64'({bus12.tx_valid, bus2.tx_valid, done12, done2}),
            64'(4'b1100));
      rx_valid = 1'b1;
      rx_data  = 8'hC0 + 8'(i);
      tick();
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    tick();
    check("s6_done_next", 64'({done12, done2}), 64'(2'b11));
    end_checks("s6", 1'b0, 1'b0);
    send_word(32'h00000013);
    check("s6_done_ignores_rx", 64'({done12, done2, busy12, busy2}), 64'(4'b1100));

    // Opcode mix, all supported.
    prog.delete();
    foreach (mix_ops[i]) prog.push_back(mix_ops[i]);
    run("s7", 1'b0, 1'b1);

    // FENCE is outside the supported set.
    prog.delete();
    prog.push_back(32'h0000000F);
    run("s8", 1'b1, 1'b1);

    tick();
    check("final_queues_empty",
          64'(exp_wr12.size() + exp_wr2.size() + exp_tx12.size() + exp_tx2.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
